// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue/writeback controller on the driving side of an 8-bit combinational
// ALU. One instruction is in flight at a time and moves through
// IDLE -> EXEC -> WB -> IDLE.
//   IDLE : instr_ready high. On a handshake the instruction fields are latched
//          and the operands R[ra], R[rb] and the opcode are registered onto
//          alu_a / alu_b / alu_sel.
//   EXEC : the ALU answer (alu_f, alu_ovf, alu_take_branch) is captured at
//          the end of the cycle.
//   WB   : done pulses high; R[rd] is written (ops 000..101) or the PC takes
//          a relative branch (ops 110/111); ovf_sticky is set by an
//          overflowing op 000.
//
// Parameters
//   PC_W      program counter width, PC arithmetic wraps modulo 2^PC_W
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   instr_valid/ready     instruction handshake, ready only in IDLE
//   instr[15:0]           [15:13]op [12:11]rd [10:9]ra [8:7]rb [6]rsvd
//                         [5:0]boff (signed branch offset)
//   alu_a, alu_b, alu_sel operands / opcode towards the ALU (held when idle)
//   alu_f, alu_ovf,       ALU result, add overflow, branch condition
//   alu_take_branch
//   host_we/waddr/wdata   host register write port, honoured any cycle
//   host_raddr/rdata      host combinational read port
//   clr_ovf               clears ovf_sticky
//   pc                    program counter
//   done                  one-cycle pulse when an instruction retires
//   ovf_sticky            set by any retired op 000 with overflow
//
// Build option
//   ALU_CTRL_ZERO_REG_EN  when defined, R0 reads as zero and all writes to R0
//                         (writeback or host) are discarded.
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [15:0]     instr,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [2:0]      alu_sel,
  input  logic [7:0]      alu_f,
  input  logic            alu_ovf,
  input  logic            alu_take_branch,
  input  logic            host_we,
  input  logic [1:0]      host_waddr,
  input  logic [7:0]      host_wdata,
  input  logic [1:0]      host_raddr,
  output logic [7:0]      host_rdata,
  input  logic            clr_ovf,
  output logic [PC_W-1:0] pc,
  output logic            done,
  output logic            ovf_sticky
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state, next_state;

  logic [7:0]        regs [4];
  logic [2:0]        op_q;
  logic [1:0]        rd_q;
  logic [5:0]        boff_q;
  logic [7:0]        f_q;
  logic              ovf_q;
  logic              branch_q;

  logic              accept;
  logic              is_branch_op;
  logic              host_reg_we;
  logic              wb_reg_we;
  logic              sticky_set;
  logic signed [5:0] boff_s;
  logic [PC_W-1:0]   branch_off;
  logic              rsvd_unused;

  // The reserved instruction bit carries no meaning.
  assign rsvd_unused = instr[6];

  // Register file read with the optional hardwired-zero R0.
  function automatic logic [7:0] rf_read(input logic [1:0] idx);
`ifdef ALU_CTRL_ZERO_REG_EN
    rf_read = (idx == 2'd0) ? 8'h00 : regs[idx];
`else
    rf_read = regs[idx];
`endif
  endfunction

  assign accept       = instr_valid && instr_ready;
  assign is_branch_op = op_q[2] & op_q[1];
  assign sticky_set   = (state == WB) && (op_q == 3'b000) && ovf_q;
  assign host_rdata   = rf_read(host_raddr);

  // Signed cast followed by a width cast sign-extends the 6-bit offset.
  assign boff_s     = $signed(boff_q);
  assign branch_off = PC_W'(boff_s);

`ifdef ALU_CTRL_ZERO_REG_EN
  assign host_reg_we = host_we && (host_waddr != 2'd0);
  assign wb_reg_we   = (state == WB) && !is_branch_op && (rd_q != 2'd0);
`else
  assign host_reg_we = host_we;
  assign wb_reg_we   = (state == WB) && !is_branch_op;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    next_state = WB;
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE:    instr_ready = 1'b1;
      WB:      done        = 1'b1;
      default: ;
    endcase
  end

  // Operands are read from the register file on the accept edge so they are
  // stable on alu_a/alu_b for the whole EXEC cycle; outside that they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rd_q     <= '0;
      boff_q   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      f_q      <= '0;
      ovf_q    <= 1'b0;
      branch_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= instr[15:13];
        rd_q    <= instr[12:11];
        boff_q  <= instr[5:0];
        alu_a   <= rf_read(instr[10:9]);
        alu_b   <= rf_read(instr[8:7]);
        alu_sel <= instr[15:13];
      end
      if (state == EXEC) begin
        f_q      <= alu_f;
        ovf_q    <= alu_ovf;
        branch_q <= alu_take_branch;
      end
    end
  end

  // The writeback assignment comes last so it wins over a same-cycle host
  // write to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (host_reg_we) begin
        regs[host_waddr] <= host_wdata;
      end
      if (wb_reg_we) begin
        regs[rd_q] <= f_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (state == WB) begin
      if (is_branch_op && branch_q) begin
        pc <= pc + branch_off;
      end else begin
        pc <= pc + PC_W'(1);
      end
    end
  end

  // A set condition overrides a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (sticky_set) begin
      ovf_sticky <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Bench for alu_issue_ctrl. The bench plays the ALU with a small
// combinational function, keeps a transaction-level model of the controller
// (register array, PC, sticky flag and a countdown of cycles left for the
// instruction in flight) and compares every DUT output against it on each
// falling edge. Directed sequences with literal expectations come first,
// then a randomized run.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  localparam int PC_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [7:0]  alu_a, alu_b, alu_f;
  logic [2:0]  alu_sel;
  logic        alu_ovf, alu_take_branch;
  logic        host_we = 1'b0;
  logic [1:0]  host_waddr = '0;
  logic [7:0]  host_wdata = '0;
  logic [1:0]  host_raddr = '0;
  logic [7:0]  host_rdata;
  logic        clr_ovf = 1'b0;
  logic [PC_W-1:0] pc;
  logic        done;
  logic        ovf_sticky;

  int n_checks = 0;
  int n_fail   = 0;
  logic checking = 1'b0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_f(alu_f), .alu_ovf(alu_ovf), .alu_take_branch(alu_take_branch),
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .host_raddr(host_raddr), .host_rdata(host_rdata),
    .clr_ovf(clr_ovf), .pc(pc), .done(done), .ovf_sticky(ovf_sticky)
  );

  // Stand-in ALU: returns {take_branch, ovf, f}. Overflow and the branch flag
  // are deliberately non-zero on unrelated ops so the controller must ignore
  // them there.
  function automatic logic [9:0] alu_fn(input logic [2:0] sel,
                                        input logic [7:0] a, input logic [7:0] b);
    int s;
    logic [7:0] f;
    logic ovf, tb;
    s   = int'($signed(a)) + int'($signed(b));
    ovf = (s > 127) || (s < -128);
    case (sel)
      3'd0:    f = a + b;
      3'd1:    f = a - b;
      3'd2:    f = a & b;
      3'd3:    f = a | b;
      3'd4:    f = a ^ b;
      3'd5:    f = ~a;
      default: f = a - b;
    endcase
    if (sel == 3'd6)      tb = (a == b);
    else if (sel == 3'd7) tb = (a != b);
    else                  tb = a[0] ^ b[1];
    return {tb, ovf, f};
  endfunction

  assign {alu_take_branch, alu_ovf, alu_f} = alu_fn(alu_sel, alu_a, alu_b);

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] ra, input logic [1:0] rb,
                                     input logic [5:0] boff);
    return {op, rd, ra, rb, 1'b0, boff};
  endfunction

  // ---------------- reference model ----------------
  logic [7:0]      m_regs [4];
  logic [PC_W-1:0] m_pc;
  logic            m_sticky;
  int              m_busy;
  logic [2:0]      m_op;
  logic [1:0]      m_rd;
  logic [5:0]      m_boff;
  logic [7:0]      m_a, m_b;
  logic [2:0]      m_sel;
  logic [9:0]      m_r;
  logic            m_wb;

  function automatic logic [7:0] m_read(input logic [1:0] idx);
`ifdef ALU_CTRL_ZERO_REG_EN
    if (idx == 2'd0) return 8'h00;
`endif
    return m_regs[idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_pc = 8'h00; m_sticky = 1'b0; m_busy = 0;
      m_op = 3'd0; m_rd = 2'd0; m_boff = 6'd0;
      m_a = 8'h00; m_b = 8'h00; m_sel = 3'd0;
    end else begin
      m_wb = (m_busy == 1);
      m_r  = alu_fn(m_sel, m_a, m_b);
      if (m_busy == 0) begin
        if (instr_valid) begin
          m_op = instr[15:13]; m_rd = instr[12:11]; m_boff = instr[5:0];
          m_a = m_read(instr[10:9]); m_b = m_read(instr[8:7]); m_sel = instr[15:13];
          m_busy = 2;
        end
      end else begin
        m_busy = m_busy - 1;
      end
      if (host_we) m_regs[host_waddr] = host_wdata;
      if (clr_ovf) m_sticky = 1'b0;
      if (m_wb) begin
        if (m_op < 3'd6) begin
          m_regs[m_rd] = m_r[7:0];
          m_pc = PC_W'(int'(m_pc) + 1);
        end else if (m_r[9]) begin
          m_pc = PC_W'(int'(m_pc) + int'($signed(m_boff)));
        end else begin
          m_pc = PC_W'(int'(m_pc) + 1);
        end
        if (m_op == 3'd0 && m_r[8]) m_sticky = 1'b1;
      end
`ifdef ALU_CTRL_ZERO_REG_EN
      m_regs[0] = 8'h00;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("instr_ready", instr_ready, m_busy == 0);
      checkOutput("done", done, m_busy == 1);
      checkOutput("pc", pc, m_pc);
      checkOutput("ovf_sticky", ovf_sticky, m_sticky);
      checkOutput("host_rdata", host_rdata, m_read(host_raddr));
      checkOutput("alu_a", alu_a, m_a);
      checkOutput("alu_b", alu_b, m_b);
      checkOutput("alu_sel", alu_sel, m_sel);
    end
  end

  // Drives one cycle of inputs; returns just after the following falling edge.
  task automatic applyStimulus(input logic v, input logic [15:0] ins,
                               input logic we, input logic [1:0] wa,
                               input logic [7:0] wd, input logic [1:0] ra,
                               input logic clr);
    instr_valid = v; instr = ins; host_we = we; host_waddr = wa;
    host_wdata = wd; host_raddr = ra; clr_ovf = clr;
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0; instr_valid = 1'b0; host_we = 1'b0; clr_ovf = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  int n_done;
  logic v;
  logic we;
  logic [7:0] wd;

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    checking = 1'b1;

    checkOutput("lit reset pc", pc, 32'h00);
    checkOutput("lit reset ready", instr_ready, 1);
    checkOutput("lit reset done", done, 0);
    checkOutput("lit reset rdata", host_rdata, 32'h00);

    // Add with overflow: R3 = 0x70 + 0x20.
    applyStimulus(0, 16'h0, 1, 2'd1, 8'h70, 2'd0, 0);
    applyStimulus(0, 16'h0, 1, 2'd2, 8'h20, 2'd1, 0);
    checkOutput("lit R1", host_rdata, 32'h70);
    applyStimulus(1, mk(3'd0, 2'd3, 2'd1, 2'd2, 6'd0), 0, 2'd0, 8'h00, 2'd3, 0);
    checkOutput("lit exec alu_a", alu_a, 32'h70);
    checkOutput("lit exec alu_b", alu_b, 32'h20);
    checkOutput("lit exec ready", instr_ready, 0);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd3, 0);
    checkOutput("lit wb done", done, 1);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd3, 0);
    checkOutput("lit R3 sum", host_rdata, 32'h90);
    checkOutput("lit sticky set", ovf_sticky, 1);
    checkOutput("lit pc 1", pc, 32'h01);

    // Taken branch backwards from pc 0 wraps to 0xFE.
    doReset();
    applyStimulus(0, 16'h0, 1, 2'd1, 8'h05, 2'd0, 0);
    applyStimulus(0, 16'h0, 1, 2'd2, 8'h05, 2'd0, 0);
    applyStimulus(1, mk(3'd6, 2'd0, 2'd1, 2'd2, 6'b111110), 0, 2'd0, 8'h00, 2'd0, 0);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd0, 0);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd0, 0);
    checkOutput("lit branch pc", pc, 32'hFE);
    checkOutput("lit branch R0", host_rdata, 32'h00);

    // Not-taken branch: pc + 1, one done pulse.
    applyStimulus(1, mk(3'd7, 2'd1, 2'd1, 2'd2, 6'd5), 0, 2'd0, 8'h00, 2'd1, 0);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd1, 0);
    checkOutput("lit nt done", done, 1);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd1, 0);
    checkOutput("lit nt pc", pc, 32'hFF);
    checkOutput("lit nt done low", done, 0);
    checkOutput("lit nt R1", host_rdata, 32'h05);

    // Host write and writeback to R3 in the same cycle: writeback wins.
    doReset();
    applyStimulus(0, 16'h0, 1, 2'd1, 8'h50, 2'd0, 0);
    applyStimulus(0, 16'h0, 1, 2'd2, 8'h05, 2'd0, 0);
    applyStimulus(1, mk(3'd0, 2'd3, 2'd1, 2'd2, 6'd0), 0, 2'd0, 8'h00, 2'd3, 0);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd3, 0);
    applyStimulus(0, 16'h0, 1, 2'd3, 8'hAA, 2'd3, 0);
    checkOutput("lit collide R3", host_rdata, 32'h55);

    // Clear coincident with set: set wins; a later clear clears.
    applyStimulus(0, 16'h0, 1, 2'd1, 8'h70, 2'd0, 0);
    applyStimulus(0, 16'h0, 1, 2'd2, 8'h20, 2'd0, 0);
    applyStimulus(1, mk(3'd0, 2'd3, 2'd1, 2'd2, 6'd0), 0, 2'd0, 8'h00, 2'd3, 0);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd3, 0);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd3, 1);
    checkOutput("lit clr vs set", ovf_sticky, 1);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd3, 1);
    checkOutput("lit clr", ovf_sticky, 0);

    // Valid held high for nine cycles: three accepts, three retirements.
    n_done = 0;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1, mk(3'(k % 6), 2'(k), 2'd1, 2'd2, 6'd0), 0, 2'd0, 8'h00, 2'd3, 0);
      if (done) n_done++;
    end
    checkOutput("lit stream dones", n_done, 3);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd3, 0);

    // Reset during EXEC abandons the instruction.
    applyStimulus(1, mk(3'd0, 2'd2, 2'd1, 2'd2, 6'd0), 0, 2'd0, 8'h00, 2'd2, 0);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("lit rst done", done, 0);
    checkOutput("lit rst pc", pc, 32'h00);
    checkOutput("lit rst R2", host_rdata, 32'h00);
    #1 rst_n = 1'b1;
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd2, 0);
    checkOutput("lit post rst done", done, 0);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd2, 0);
    checkOutput("lit post rst done2", done, 0);

`ifdef ALU_CTRL_ZERO_REG_EN
    applyStimulus(0, 16'h0, 1, 2'd0, 8'h33, 2'd0, 0);
    checkOutput("lit R0 host", host_rdata, 32'h00);
    applyStimulus(0, 16'h0, 1, 2'd1, 8'h11, 2'd0, 0);
    applyStimulus(1, mk(3'd3, 2'd0, 2'd1, 2'd1, 6'd0), 0, 2'd0, 8'h00, 2'd0, 0);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd0, 0);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd0, 0);
    checkOutput("lit R0 wb", host_rdata, 32'h00);
`endif

    // Randomized run; host writes avoid the accept and EXEC cycles.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) doReset();
      v  = ($urandom_range(0, 9) < 7);
      we = 1'b0;
      if ((m_busy == 0 && !v) || m_busy == 1) we = ($urandom_range(0, 2) == 0);
      wd = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      applyStimulus(v, 16'($urandom), we, 2'($urandom_range(0, 3)), wd,
                    2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
    end

    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd0, 0);
    applyStimulus(0, 16'h0, 0, 2'd0, 8'h00, 2'd0, 0);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
